// File: rtl/bas_lfsr_pkg.sv
// Shared definitions for the twin 9-bit LFSR BFloat16 random source:
// framing constants, the next-state function and the checker FSM encoding.
package bas_lfsr_pkg;

    localparam int unsigned STATE_W = 9;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned EXP_W   = 5;

    localparam logic [EXP_W-1:0] EXP_FIELD = 5'b01111;
    localparam logic             BIT8      = 1'b1;
    localparam logic             BIT7      = 1'b0;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } fsm_t;

    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic               fmt_err;
        logic               degenerate;
        logic               mismatch;
    } lane_info_t;

    // Two independent sub-registers: bits [8:5] (4-bit) and [4:0] (5-bit).
    function automatic logic [STATE_W-1:0] lfsr9_next(input logic [STATE_W-1:0] s);
        return {s[7], s[6], s[5] ^ s[8], s[8], s[0], s[4], s[3] ^ s[0], s[2], s[1]};
    endfunction

endpackage

// File: rtl/lfsr9_lane_decode.sv
// Per-lane unpack of a BFloat16 word into the 9-bit LFSR state, with framing,
// stuck-at-zero and prediction-compare flags.
module lfsr9_lane_decode
    import bas_lfsr_pkg::*;
(
    input  logic [WORD_W-1:0]  word,
    input  logic [STATE_W-1:0] pred,
    output lane_info_t         info_c
);

    logic [STATE_W-1:0] s;

    always_comb begin
        s                 = {word[15], word[9], word[6:0]};
        info_c.state      = s;
        info_c.fmt_err    = (word[14:10] != EXP_FIELD) || (word[8] != BIT8) || (word[7] != BIT7);
        info_c.degenerate = (s[8:5] == 4'd0) || (s[4:0] == 5'd0);
        info_c.mismatch   = (s != pred);
    end

endmodule

// File: rtl/twin_lfsr_checker.sv
// Receive-side decoder and lock checker for the twin 9-bit LFSR BFloat16
// streams: recovers both lane states, predicts the next ones and tracks lock.
module twin_lfsr_checker
    import bas_lfsr_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned MISS_LIMIT = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic [WORD_W-1:0]  n1,
    input  logic [WORD_W-1:0]  n2,
    output logic               out_valid,
    output logic [STATE_W-1:0] state1,
    output logic [STATE_W-1:0] state2,
    output logic [1:0]         fmt_err,
    output logic [1:0]         mismatch,
    output logic [1:0]         degenerate,
    output logic               locked,
    output logic [CNT_W-1:0]   err_count,
    output logic [1:0]         fsm_state
);

    localparam int unsigned MCNT_W = 4;

    fsm_t               state_q, state_d;
    logic [STATE_W-1:0] pred1_q, pred1_d, pred2_q, pred2_d;
    logic [MCNT_W-1:0]  match_cnt_q, match_cnt_d;
    logic [MCNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]   err_d;
    lane_info_t         lane1_c, lane2_c;
    logic [1:0]         mismatch_c;
    logic               any_fmt_c, any_mis_c;

    lfsr9_lane_decode u_lane1 (.word(n1), .pred(pred1_q), .info_c(lane1_c));
    lfsr9_lane_decode u_lane2 (.word(n2), .pred(pred2_q), .info_c(lane2_c));

    // Next-state and prediction logic; only a valid sample moves anything.
    always_comb begin
        state_d     = state_q;
        pred1_d     = pred1_q;
        pred2_d     = pred2_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = err_count;
        mismatch_c  = (state_q != HUNT) ? {lane2_c.mismatch, lane1_c.mismatch} : 2'b00;
        any_fmt_c   = lane1_c.fmt_err | lane2_c.fmt_err;
        any_mis_c   = |mismatch_c;

        if (valid) begin
            case (state_q)
                HUNT: begin
                    if (!any_fmt_c) begin
                        pred1_d     = lfsr9_next(lane1_c.state);
                        pred2_d     = lfsr9_next(lane2_c.state);
                        match_cnt_d = '0;
                        state_d     = VERIFY;
                    end
                end
                VERIFY: begin
                    pred1_d = lfsr9_next(lane1_c.state);
                    pred2_d = lfsr9_next(lane2_c.state);
                    if (any_fmt_c) begin
                        match_cnt_d = '0;
                        state_d     = HUNT;
                    end else if (any_mis_c) begin
                        match_cnt_d = '0;
                    end else if (match_cnt_q == MCNT_W'(LOCK_COUNT - 1)) begin
                        match_cnt_d = '0;
                        miss_cnt_d  = '0;
                        state_d     = LOCKED;
                    end else begin
                        match_cnt_d = match_cnt_q + MCNT_W'(1);
                    end
                end
                LOCKED: begin
                    // Free-run so one corrupt sample cannot poison the prediction.
                    pred1_d = lfsr9_next(pred1_q);
                    pred2_d = lfsr9_next(pred2_q);
                    if (any_fmt_c || any_mis_c) begin
                        if (err_count != '1) begin
                            err_d = err_count + CNT_W'(1);
                        end
                        if (miss_cnt_q == MCNT_W'(MISS_LIMIT - 1)) begin
                            miss_cnt_d = '0;
                            state_d    = HUNT;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MCNT_W'(1);
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; per-sample outputs hold while valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            pred1_q     <= '0;
            pred2_q     <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_count   <= '0;
            out_valid   <= 1'b0;
            locked      <= 1'b0;
            state1      <= '0;
            state2      <= '0;
            fmt_err     <= '0;
            mismatch    <= '0;
            degenerate  <= '0;
        end else begin
            pred1_q     <= pred1_d;
            pred2_q     <= pred2_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_count   <= err_d;
            out_valid   <= valid;
            locked      <= (state_d == LOCKED);
            if (valid) begin
                state1     <= lane1_c.state;
                state2     <= lane2_c.state;
                fmt_err    <= {lane2_c.fmt_err, lane1_c.fmt_err};
                mismatch   <= mismatch_c;
                degenerate <= {lane2_c.degenerate, lane1_c.degenerate};
            end
        end
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_twin_lfsr_checker.sv
// Directed bench for twin_lfsr_checker: a hand-computed vector table plus
// sequences for mid-stream reset and error-counter saturation.
module tb_twin_lfsr_checker;

    localparam int unsigned CW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid;
    logic [15:0]   n1, n2;
    logic          out_valid;
    logic [8:0]    state1, state2;
    logic [1:0]    fmt_err, mismatch, degenerate;
    logic          locked;
    logic [CW-1:0] err_count;
    logic [1:0]    fsm_state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        v;
        logic [15:0] a, b;
        logic [8:0]  s1, s2;
        logic [1:0]  fmt, mis, deg, fsm;
        logic        lk;
        logic [4:0]  err;
    } vec_t;

    vec_t       vecs[25];
    logic [8:0] p1, p2;

    always #5 clk = ~clk;

    twin_lfsr_checker #(.LOCK_COUNT(4), .MISS_LIMIT(3), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .valid(valid), .n1(n1), .n2(n2),
        .out_valid(out_valid), .state1(state1), .state2(state2),
        .fmt_err(fmt_err), .mismatch(mismatch), .degenerate(degenerate),
        .locked(locked), .err_count(err_count), .fsm_state(fsm_state)
    );

    function automatic logic [15:0] enc(input logic [8:0] s);
        return {s[8], 5'b01111, s[7], 1'b1, 1'b0, s[6:0]};
    endfunction

    function automatic logic [8:0] nxt(input logic [8:0] s);
        return {s[7], s[6], s[5] ^ s[8], s[8], s[0], s[4], s[3] ^ s[0], s[2], s[1]};
    endfunction

    function automatic vec_t mk(input logic v, input logic [15:0] a, input logic [15:0] b,
                                input logic [8:0] s1, input logic [8:0] s2,
                                input logic [1:0] fmt, input logic [1:0] mis,
                                input logic [1:0] deg, input logic [1:0] fsm,
                                input logic lk, input logic [4:0] err);
        vec_t r;
        r.v = v; r.a = a; r.b = b; r.s1 = s1; r.s2 = s2; r.fmt = fmt;
        r.mis = mis; r.deg = deg; r.fsm = fsm; r.lk = lk; r.err = err;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic v, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        valid = v;
        n1    = a;
        n2    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".state1"}, 32'(state1), 32'd0);
        check({tag, ".state2"}, 32'(state2), 32'd0);
        check({tag, ".fmt_err"}, 32'(fmt_err), 32'd0);
        check({tag, ".mismatch"}, 32'(mismatch), 32'd0);
        check({tag, ".degenerate"}, 32'(degenerate), 32'd0);
        check({tag, ".locked"}, 32'(locked), 32'd0);
        check({tag, ".err_count"}, 32'(err_count), 32'd0);
        check({tag, ".fsm_state"}, 32'(fsm_state), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        send(1'b1, 16'hBD01, 16'hBD01);
        reset = 1'b0;
    endtask

    task automatic lock_up(input logic [8:0] a, input logic [8:0] b);
        p1 = a;
        p2 = b;
        for (int k = 0; k < 5; k++) begin
            send(1'b1, enc(p1), enc(p2));
            p1 = nxt(p1);
            p2 = nxt(p2);
        end
    endtask

    task automatic good();
        send(1'b1, enc(p1), enc(p2));
        p1 = nxt(p1);
        p2 = nxt(p2);
    endtask

    task automatic bad();
        send(1'b1, enc(p1) ^ 16'h0001, enc(p2));
        p1 = nxt(p1);
        p2 = nxt(p2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Lane-1 stream from 9'h101: 101 074 0CA 185 176 0AB 151 0FC 1CE 1E7 1B7 13F 03B 059 098 10C 066 0C3
        vecs[0]  = mk(1, enc(9'h101), enc(9'h0AB), 9'h101, 9'h0AB, 2'b00, 2'b00, 2'b00, 2'd1, 0, 5'd0);
        vecs[1]  = mk(1, enc(9'h074), enc(9'h151), 9'h074, 9'h151, 2'b00, 2'b00, 2'b00, 2'd1, 0, 5'd0);
        vecs[2]  = mk(0, 16'h0000, 16'hFFFF,       9'h074, 9'h151, 2'b00, 2'b00, 2'b00, 2'd1, 0, 5'd0);
        vecs[3]  = mk(1, enc(9'h0CA), enc(9'h0FC), 9'h0CA, 9'h0FC, 2'b00, 2'b00, 2'b00, 2'd1, 0, 5'd0);
        vecs[4]  = mk(1, enc(9'h185), enc(9'h1CE), 9'h185, 9'h1CE, 2'b00, 2'b00, 2'b00, 2'd1, 0, 5'd0);
        vecs[5]  = mk(0, 16'h1234, 16'h0000,       9'h185, 9'h1CE, 2'b00, 2'b00, 2'b00, 2'd1, 0, 5'd0);
        vecs[6]  = mk(1, enc(9'h176), enc(9'h1E7), 9'h176, 9'h1E7, 2'b00, 2'b00, 2'b00, 2'd2, 1, 5'd0);
        vecs[7]  = mk(1, enc(9'h0AB), enc(9'h1B7), 9'h0AB, 9'h1B7, 2'b00, 2'b00, 2'b00, 2'd2, 1, 5'd0);
        vecs[8]  = mk(0, 16'hFFFF, 16'hFFFF,       9'h0AB, 9'h1B7, 2'b00, 2'b00, 2'b00, 2'd2, 1, 5'd0);
        vecs[9]  = mk(1, enc(9'h151), enc(9'h13F), 9'h151, 9'h13F, 2'b00, 2'b00, 2'b00, 2'd2, 1, 5'd0);
        vecs[10] = mk(1, enc(9'h0FC), enc(9'h03B) ^ 16'h0008, 9'h0FC, 9'h033, 2'b00, 2'b10, 2'b00, 2'd2, 1, 5'd1);
        vecs[11] = mk(1, enc(9'h1CE), enc(9'h059), 9'h1CE, 9'h059, 2'b00, 2'b00, 2'b00, 2'd2, 1, 5'd1);
        vecs[12] = mk(1, enc(9'h1E7), enc(9'h098), 9'h1E7, 9'h098, 2'b00, 2'b00, 2'b00, 2'd2, 1, 5'd1);
        vecs[13] = mk(1, enc(9'h1B7) | 16'h0080, enc(9'h10C), 9'h1B7, 9'h10C, 2'b01, 2'b00, 2'b00, 2'd2, 1, 5'd2);
        vecs[14] = mk(1, enc(9'h13F) | 16'h0080, enc(9'h066), 9'h13F, 9'h066, 2'b01, 2'b00, 2'b00, 2'd2, 1, 5'd3);
        vecs[15] = mk(1, enc(9'h03B) | 16'h0080, enc(9'h0C3), 9'h03B, 9'h0C3, 2'b01, 2'b00, 2'b00, 2'd0, 0, 5'd4);
        vecs[16] = mk(1, 16'hBD81, enc(9'h0AB) & ~16'h0100,   9'h101, 9'h0AB, 2'b11, 2'b00, 2'b00, 2'd0, 0, 5'd4);
        vecs[17] = mk(1, enc(9'h101), enc(9'h0AB) ^ 16'h0400, 9'h101, 9'h0AB, 2'b10, 2'b00, 2'b00, 2'd0, 0, 5'd4);
        vecs[18] = mk(1, 16'hBD01, enc(9'h0AB),    9'h101, 9'h0AB, 2'b00, 2'b00, 2'b00, 2'd1, 0, 5'd4);
        vecs[19] = mk(1, enc(9'h074), enc(9'h1B7), 9'h074, 9'h1B7, 2'b00, 2'b10, 2'b00, 2'd1, 0, 5'd4);
        vecs[20] = mk(1, enc(9'h0CA), enc(9'h13F), 9'h0CA, 9'h13F, 2'b00, 2'b00, 2'b00, 2'd1, 0, 5'd4);
        vecs[21] = mk(1, enc(9'h000), enc(9'h01F), 9'h000, 9'h01F, 2'b00, 2'b11, 2'b11, 2'd1, 0, 5'd4);
        vecs[22] = mk(1, enc(9'h000), enc(9'h01B), 9'h000, 9'h01B, 2'b00, 2'b00, 2'b11, 2'd1, 0, 5'd4);
        vecs[23] = mk(1, enc(9'h101), enc(9'h019), 9'h101, 9'h019, 2'b00, 2'b01, 2'b10, 2'd1, 0, 5'd4);
        vecs[24] = mk(1, enc(9'h074) | 16'h0080, enc(9'h018), 9'h074, 9'h018, 2'b01, 2'b00, 2'b10, 2'd0, 0, 5'd4);

        reset = 1'b1;
        valid = 1'b0;
        n1    = 16'h0000;
        n2    = 16'h0000;
        send(1'b1, 16'hBD01, 16'hBD01);
        send(1'b1, 16'hBD01, 16'hBD01);
        check_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            send(vecs[i].v, vecs[i].a, vecs[i].b);
            check($sformatf("r%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].v));
            check($sformatf("r%0d.state1", i), 32'(state1), 32'(vecs[i].s1));
            check($sformatf("r%0d.state2", i), 32'(state2), 32'(vecs[i].s2));
            check($sformatf("r%0d.fmt_err", i), 32'(fmt_err), 32'(vecs[i].fmt));
            check($sformatf("r%0d.mismatch", i), 32'(mismatch), 32'(vecs[i].mis));
            check($sformatf("r%0d.degenerate", i), 32'(degenerate), 32'(vecs[i].deg));
            check($sformatf("r%0d.fsm_state", i), 32'(fsm_state), 32'(vecs[i].fsm));
            check($sformatf("r%0d.locked", i), 32'(locked), 32'(vecs[i].lk));
            check($sformatf("r%0d.err_count", i), 32'(err_count), 32'(vecs[i].err));
        end

        // Mid-stream reset while locked with five errors recorded.
        do_reset();
        lock_up(9'h101, 9'h0AB);
        check("a.locked", 32'(locked), 32'd1);
        for (int k = 0; k < 5; k++) begin
            good();
            bad();
        end
        check("a.err5", 32'(err_count), 32'd5);
        check("a.mis_lane1", 32'(mismatch), 32'd1);
        check("a.still_locked", 32'(fsm_state), 32'd2);
        reset = 1'b1;
        send(1'b1, enc(p1), enc(p2));
        check_zero("a.reset");
        reset = 1'b0;
        send(1'b1, enc(p1), enc(p2));
        check("a.post.fsm", 32'(fsm_state), 32'd1);
        check("a.post.state1", 32'(state1), 32'(p1));
        check("a.post.err", 32'(err_count), 32'd0);

        // Saturation of the error counter at all-ones.
        do_reset();
        lock_up(9'h176, 9'h1E7);
        for (int k = 0; k < 30; k++) begin
            bad();
            good();
        end
        check("b.err30", 32'(err_count), 32'd30);
        bad();
        check("b.err31", 32'(err_count), 32'd31);
        good();
        bad();
        check("b.sat1", 32'(err_count), 32'd31);
        good();
        bad();
        check("b.sat2", 32'(err_count), 32'd31);
        check("b.locked", 32'(locked), 32'd1);
        check("b.mis", 32'(mismatch), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/twin_lfsr_checker.md
Name: twin_lfsr_checker

Overview:
- Receive-side decoder and checker for the twin 9-bit LFSR BFloat16 random streams used by the BAS direction generator.
- Each cycle with valid high, it strips the fixed BFloat16 framing bits and recovers the 9-bit LFSR state of both lanes.
- It predicts the next state of each lane and tracks lock with an FSM (HUNT/VERIFY/LOCKED), counting mismatches.
- Sits on the n1/n2 bus as a self-check monitor; also synthesised for on-chip BIST of the BAS random source.

Parameters:
LOCK_COUNT, 4, consecutive matching samples in VERIFY required to enter LOCKED (1..15)
MISS_LIMIT, 3, consecutive mismatching samples in LOCKED that force return to HUNT (1..15)
CNT_W, 16, width of saturating error counter

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
valid  input  1  n1/n2 carry a new sample this cycle
n1  input  16  lane-1 BFloat16 word
n2  input  16  lane-2 BFloat16 word
out_valid  output  1  registered copy of valid; qualifies state1/state2/fmt_err/mismatch
state1  output  9  recovered lane-1 LFSR state
state2  output  9  recovered lane-2 LFSR state
fmt_err  output  2  per lane: framing bits wrong
mismatch  output  2  per lane: recovered state differs from prediction (VERIFY/LOCKED only)
degenerate  output  2  per lane: recovered bits [8:5]==0 or [4:0]==0 (sub-register stuck at zero)
locked  output  1  FSM in LOCKED
err_count  output  CNT_W  saturating count of samples flagged mismatch (either lane) or fmt_err while LOCKED
fsm_state  output  2  0=HUNT, 1=VERIFY, 2=LOCKED

Behaviour:
- Reset: all outputs 0, fsm_state=HUNT, predictions 0. Reset mid-stream behaves identically; the sample presented in the reset cycle is ignored.
- Decode, per lane, for word n: s[8]=n[15], s[7]=n[9], s[6:0]=n[6:0].
- Framing check: fmt_err[i]=1 unless n[14:10]==5'b01111, n[8]==1 and n[7]==0.
- Next-state function f(s), shared with the generator:
  f[8]=s[7], f[7]=s[6], f[6]=s[5]^s[8], f[5]=s[8], f[4]=s[0], f[3]=s[4], f[2]=s[3]^s[0], f[1]=s[2], f[0]=s[1].
- Latency: all per-sample outputs are registered 1 cycle after the valid input. Cycles with valid=0 change nothing except out_valid=0, and the prediction does not advance.
- Hold rule: state1/state2/fmt_err/mismatch/degenerate hold their last value while out_valid=0.
- FSM, per valid sample (both lanes jointly):
  - HUNT: if no fmt_err, load pred_i=f(s_i), match_cnt=0, go to VERIFY. If fmt_err, stay in HUNT. mismatch=0.
  - VERIFY: if both lanes match and there is no fmt_err, match_cnt++ and pred_i=f(s_i). On reaching LOCK_COUNT, go to LOCKED.
  - VERIFY, any mismatch or fmt_err: reload pred_i=f(s_i) from the received sample, match_cnt=0, stay in VERIFY. If fmt_err, go to HUNT instead.
  - LOCKED: pred_i=f(pred_i), i.e. free-run from the prediction so a single corrupt sample does not propagate. Any lane mismatch or fmt_err increments err_count and miss_cnt.
  - LOCKED, clean sample: clears miss_cnt.
  - LOCKED, miss_cnt reaching MISS_LIMIT: go to HUNT, miss_cnt=0.
- err_count saturates at all-ones; it is cleared only by reset.
- A degenerate lane is reported but does not by itself cause a mismatch.

Decomposition:
- Shared package bas_lfsr_pkg: framing constants EXP_FIELD=5'b01111, BIT8=1, BIT7=0; function lfsr9_next (above); FSM state encoding.
- The generator is refactored to use the same package function.
- One natural sub-module: lfsr9_lane_decode (per-lane unpack, framing check, degenerate detect, compare against prediction), instantiated twice.

Test Plan:
- Reset then valid with n1=n2=16'hBD01 (s=9'h101), next n1=n2=16'h3D74 (s=9'h074) -> state1=9'h101 then 9'h074; fsm_state HUNT->VERIFY; mismatch=0.
- Drive an exact lane stream from the reference model for seeds 9'h101/9'h0AB, 10 samples with valid gaps -> locked=1 after 1+LOCK_COUNT samples; err_count=0; gaps do not advance the prediction.
- When locked, corrupt one lane-2 sample (flip n2[3]), then resume the correct sequence -> mismatch=2'b10 for one sample, err_count=1, stays LOCKED, following samples match.
- When locked, inject n1=16'hBD81 (bit7 set) -> fmt_err=2'b01, err_count increments. Three consecutive bad samples -> fsm_state=HUNT.
- Lane seed 9'h000 -> degenerate=2'b11. Seed 9'h01F -> degenerate[i]=1 (bits[8:5]==0).
- Assert reset for one cycle while LOCKED with err_count=5 -> next cycle all outputs 0, HUNT; force err_count to all-ones minus 1 plus 3 errors -> saturates.
